// File: rtl/multicycle_adder_ctrl.sv
// WIDTH-bit add/subtract computed over WIDTH/CHUNK cycles by reusing a single
// CHUNK-bit ripple-carry slice, LSB slice first, with valid/ready on both sides.

module ripple_carry_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         cout_o,
   output logic         prev_cout_o
);
   logic [W:0] c;

   assign c[0] = cin_i;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         assign s_o[gi]   = a_i[gi] ^ b_i[gi] ^ c[gi];
         assign c[gi + 1] = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
      end
   endgenerate

   // Carry into the MSB; XOR with cout gives signed overflow.
   assign cout_o      = c[W];
   assign prev_cout_o = c[W-1];
endmodule

module multicycle_adder_ctrl #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             overflow
);
   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic [CHUNK-1:0] slice_a, slice_b, slice_s;
   logic             slice_cout, slice_prev;

   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (idx_q == IDXW'(k)) begin
            slice_a = a_q[k*CHUNK +: CHUNK];
            slice_b = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   ripple_carry_adder #(
      .W(CHUNK)
   ) u_slice (
      .a_i        (slice_a),
      .b_i        (slice_b),
      .cin_i      (carry_q),
      .s_o        (slice_s),
      .cout_o     (slice_cout),
      .prev_cout_o(slice_prev)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            // Subtraction is A + ~B + 1, the +1 entering as the first carry-in.
            if (in_valid) begin
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
               if (idx_q == IDXW'(k)) begin
                  s_d[k*CHUNK +: CHUNK] = slice_s;
               end
            end
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               ovf_d   = slice_prev ^ slice_cout;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign S         = s_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Bench for multicycle_adder_ctrl: three instances (CHUNK = 8, 32, 1) driven by
// directed vectors, reset/backpressure sequences and random ops vs. an arithmetic model.

module tb_multicycle_adder_ctrl;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [NI];
   logic        in_ready  [NI];
   logic [31:0] A         [NI];
   logic [31:0] B         [NI];
   logic        sub       [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   logic [31:0] S         [NI];
   logic        cout      [NI];
   logic        overflow  [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         localparam int CH = (gi == 0) ? 8 : ((gi == 1) ? 32 : 1);
         multicycle_adder_ctrl #(
            .WIDTH(32),
            .CHUNK(CH)
         ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .A        (A[gi]),
            .B        (B[gi]),
            .sub      (sub[gi]),
            .out_valid(out_valid[gi]),
            .out_ready(out_ready[gi]),
            .S        (S[gi]),
            .cout     (cout[gi]),
            .overflow (overflow[gi])
         );
      end
   endgenerate

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] es;
      logic        ec;
      logic        eo;
   } vec_t;

   function automatic int lat_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
   endfunction

   // Reference: plain unsigned/signed arithmetic on wide integers.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] rs, output logic rc, output logic ro);
      longint sa, sb, sr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         rs = a - b;
         rc = (a >= b);
         sr = sa - sb;
      end else begin
         rs = a + b;
         rc = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
         sr = sa + sb;
      end
      ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input int pre_idle, input int stall, input bit junk, input string tag);
      int lat;
      int guard;
      repeat (pre_idle) tick();
      guard = 0;
      while (!in_ready[k] && guard < 50) begin
         tick();
         guard++;
      end
      chk({tag, " in_ready before accept"}, 32'(in_ready[k]), 32'd1);
      in_valid[k] = 1'b1;
      A[k]        = a;
      B[k]        = b;
      sub[k]      = s;
      tick();
      lat = 0;
      while (!out_valid[k] && lat < 100) begin
         in_valid[k] = junk ? 1'b1 : 1'($urandom_range(0, 1));
         A[k]        = $urandom;
         B[k]        = $urandom;
         sub[k]      = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(lat_of(k)));
      for (int i = 0; i < stall; i++) begin
         out_ready[k] = 1'b0;
         in_valid[k]  = junk ? 1'b1 : 1'($urandom_range(0, 1));
         A[k]         = $urandom;
         B[k]         = $urandom;
         chk({tag, " stall S"}, S[k], es);
         chk({tag, " stall in_ready"}, 32'(in_ready[k]), 32'd0);
         tick();
      end
      chk({tag, " out_valid"}, 32'(out_valid[k]), 32'd1);
      chk({tag, " S"}, S[k], es);
      chk({tag, " cout"}, 32'(cout[k]), 32'(ec));
      chk({tag, " overflow"}, 32'(overflow[k]), 32'(eo));
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      chk({tag, " out_valid after handshake"}, 32'(out_valid[k]), 32'd0);
      chk({tag, " in_ready after handshake"}, 32'(in_ready[k]), 32'd1);
      chk({tag, " S held"}, S[k], es);
      $display("%s inst=%0d a=%h b=%h sub=%0d -> S=%h cout=%0d ovf=%0d lat=%0d",
               tag, k, a, b, s, S[k], cout[k], overflow[k], lat);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [6];
      logic [31:0] corner [4];
      logic [31:0] ra, rb, es;
      logic        rs, ec, eo;
      int          nops;

      vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vt[5] = '{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      corner[0] = 32'h0000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF;

      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         A[k]         = '0;
         B[k]         = '0;
         sub[k]       = 1'b0;
      end
      repeat (2) tick();
      for (int k = 0; k < NI; k++) begin
         chk("reset in_ready", 32'(in_ready[k]), 32'd1);
         chk("reset out_valid", 32'(out_valid[k]), 32'd0);
         chk("reset S", S[k], 32'd0);
         chk("reset cout", 32'(cout[k]), 32'd0);
         chk("reset overflow", 32'(overflow[k]), 32'd0);
      end
      rst = 1'b0;
      tick();

      for (int k = 0; k < NI; k++) begin
         for (int v = 0; v < 6; v++) begin
            run_op(k, vt[v].a, vt[v].b, vt[v].s, vt[v].es, vt[v].ec, vt[v].eo, 0, 0, 1'b0, "vec");
         end
      end

      // Reset in the middle of CALC on the CHUNK=8 instance.
      in_valid[0] = 1'b1;
      A[0]        = 32'h1234_5678;
      B[0]        = 32'h0000_0001;
      sub[0]      = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("midreset in_ready", 32'(in_ready[0]), 32'd1);
      chk("midreset out_valid", 32'(out_valid[0]), 32'd0);
      chk("midreset S", S[0], 32'd0);
      chk("midreset cout", 32'(cout[0]), 32'd0);
      chk("midreset overflow", 32'(overflow[0]), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("postreset out_valid", 32'(out_valid[0]), 32'd0);
      end
      $display("midreset inst=0 a=12345678 b=00000001 discarded");

      // Backpressure: 10 stalled cycles with in_valid held high, then a new op back to back.
      run_op(0, 32'h0000_1234, 32'h0000_4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0, 0, 10, 1'b1, "bp");
      run_op(0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 32'hDEAD_BEEE, 1'b1, 1'b0, 0, 0, 1'b0, "bp-next");

      for (int k = 0; k < NI; k++) begin
         nops = 1000;
         for (int n = 0; n < nops; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec, eo);
            run_op(k, ra, rb, rs, es, ec, eo, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, "rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
